fir_coeff_sequencer: RTL and testbench

//  Loads a new coefficient set into adaptive_fir_filter's coefficient registers without corrupting an output sample.

---
 rtl/fir_coeff_sequencer_pkg.sv | 13 +
 rtl/fir_coeff_shadow.sv | 60 ++++++
 rtl/fir_coeff_sequencer.sv | 151 +++++++++++++++
 tb/tb_fir_coeff_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coeff_sequencer_pkg.sv
// Shared definitions for the coefficient sequencer: state encoding and default sizes.
package fir_coeff_sequencer_pkg;

    localparam int unsigned NtapsDefault = 8;
    localparam int unsigned CwDefault    = 16;

    typedef enum logic [1:0] {
        StLoad   = 2'd0,
        StArmed  = 2'd1,
        StCommit = 2'd2
    } state_e;

endpackage

// File: rtl/fir_coeff_shadow.sv
// Shadow coefficient bank: NTAPS x CW registers plus a per-tap written mask.
// mask_full reports whether every tap is covered once the current write lands.
module fir_coeff_shadow
    import fir_coeff_sequencer_pkg::*;
#(
    parameter int unsigned NTAPS = NtapsDefault,
    parameter int unsigned CW    = CwDefault,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [CW-1:0] wdata,
    input  logic                 mask_clr,
    input  logic [AW-1:0]        raddr,
    output logic signed [CW-1:0] rdata,
    output logic                 mask_full
);

    localparam logic [AW:0] NtapsW = (AW + 1)'(NTAPS);

    logic signed [CW-1:0] shadow_q [NTAPS];
    logic signed [CW-1:0] shadow_d [NTAPS];
    logic [NTAPS-1:0]     mask_q, mask_d, wbit;
    logic                 w_ok, r_ok;

    assign w_ok = we && ({1'b0, waddr} < NtapsW);
    assign r_ok = {1'b0, raddr} < NtapsW;

    // One-hot of the tap being written this cycle (zero when no valid write).
    always_comb begin
        wbit = '0;
        if (w_ok) wbit[waddr] = 1'b1;
    end

    // Next-state of bank and mask.
    always_comb begin
        shadow_d = shadow_q;
        mask_d   = mask_q;
        if (mask_clr) mask_d = '0;
        if (w_ok) shadow_d[waddr] = wdata;
        mask_d = mask_d | wbit;
    end

    // Bank and mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) shadow_q[i] <= '0;
            mask_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
        end
    end

    assign rdata     = r_ok ? shadow_q[raddr] : '0;
    assign mask_full = &(mask_q | wbit);

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Collects coefficient beats into a shadow bank and, at the next sample boundary,
// writes the set into the filter one tap per cycle while holding the input off.
module fir_coeff_sequencer
    import fir_coeff_sequencer_pkg::*;
#(
    parameter int unsigned NTAPS = NtapsDefault,
    parameter int unsigned CW    = CwDefault,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [AW-1:0]        cfg_addr,
    input  logic signed [CW-1:0] cfg_data,
    input  logic                 cfg_last,
    input  logic                 sample_valid,
    output logic                 hold,
    output logic                 coeff_we,
    output logic [AW-1:0]        coeff_addr,
    output logic signed [CW-1:0] coeff_data,
    output logic                 commit_done,
    input  logic                 err_clr,
    output logic                 cfg_err,
    output logic                 drop_err
);

    localparam logic [AW:0]   NtapsW  = (AW + 1)'(NTAPS);
    localparam logic [AW-1:0] LastIdx = AW'(NTAPS - 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic                 hold_q, hold_d;
    logic                 we_q, we_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 drop_err_q, drop_err_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic signed [CW-1:0] data_q, data_d;
    logic                 beat, beat_in_range, mask_full, mask_clr, err_set;
    logic [AW-1:0]        rd_addr;
    logic signed [CW-1:0] rd_data;

    assign cfg_ready     = (state_q == StLoad) & ~rst;
    assign beat          = cfg_valid & cfg_ready;
    assign beat_in_range = {1'b0, cfg_addr} < NtapsW;
    // Tap presented on the next cycle: 0 when leaving ARMED, else the one after idx.
    assign rd_addr       = (state_q == StCommit) ? idx_q + 1'b1 : '0;

    fir_coeff_shadow #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .AW    (AW)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .we        (beat & beat_in_range),
        .waddr     (cfg_addr),
        .wdata     (cfg_data),
        .mask_clr  (mask_clr),
        .raddr     (rd_addr),
        .rdata     (rd_data),
        .mask_full (mask_full)
    );

    // Next state, next registered outputs and sticky error flags.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = 1'b0;
        we_d     = 1'b0;
        addr_d   = '0;
        data_d   = '0;
        done_d   = 1'b0;
        mask_clr = 1'b0;
        err_set  = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (beat) begin
                    if (!beat_in_range) err_set = 1'b1;
                    if (cfg_last) begin
                        state_d = StArmed;
                        if (!mask_full) err_set = 1'b1;
                    end
                end
            end
            StArmed: begin
                if (sample_valid) begin
                    state_d = StCommit;
                    idx_d   = '0;
                    we_d    = 1'b1;
                    hold_d  = 1'b1;
                    addr_d  = '0;
                    data_d  = rd_data;
                end
            end
            StCommit: begin
                if (idx_q == LastIdx) begin
                    state_d  = StLoad;
                    idx_d    = '0;
                    done_d   = 1'b1;
                    mask_clr = 1'b1;
                end else begin
                    idx_d  = rd_addr;
                    we_d   = 1'b1;
                    hold_d = 1'b1;
                    addr_d = rd_addr;
                    data_d = rd_data;
                end
            end
            default: state_d = StLoad;
        endcase
        // A new error event beats a simultaneous clear.
        cfg_err_d  = err_set | (cfg_err_q & ~err_clr);
        drop_err_d = (sample_valid & hold_q) | (drop_err_q & ~err_clr);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StLoad;
            idx_q      <= '0;
            hold_q     <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            drop_err_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            drop_err_q <= drop_err_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign hold        = hold_q;
    assign coeff_we    = we_q;
    assign coeff_addr  = addr_q;
    assign coeff_data  = data_q;
    assign commit_done = done_q;
    assign cfg_err     = cfg_err_q;
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Bench for fir_coeff_sequencer: directed vector table, hand-written corner sequences,
// and randomized coefficient sets checked against a transaction-level model.
module tb_fir_coeff_sequencer;

    localparam int unsigned NT = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance (NTAPS=8)
    logic                 cfg_valid = 1'b0, cfg_last = 1'b0, sample_valid = 1'b0, err_clr = 1'b0;
    logic [AW-1:0]        cfg_addr = '0;
    logic signed [CW-1:0] cfg_data = '0;
    logic                 cfg_ready, hold, coeff_we, commit_done, cfg_err, drop_err;
    logic [AW-1:0]        coeff_addr;
    logic signed [CW-1:0] coeff_data;

    // Second instance (NTAPS=6) for the out-of-range address case
    logic                 v6 = 1'b0, l6 = 1'b0, sv6 = 1'b0, ec6 = 1'b0;
    logic [AW-1:0]        a6 = '0;
    logic signed [CW-1:0] d6 = '0;
    logic                 r6, h6, we6, dn6, ce6, de6;
    logic [AW-1:0]        ca6;
    logic signed [CW-1:0] cd6;

    fir_coeff_sequencer #(.NTAPS(NT), .CW(CW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .sample_valid(sample_valid), .hold(hold), .coeff_we(coeff_we),
        .coeff_addr(coeff_addr), .coeff_data(coeff_data), .commit_done(commit_done),
        .err_clr(err_clr), .cfg_err(cfg_err), .drop_err(drop_err)
    );

    fir_coeff_sequencer #(.NTAPS(6), .CW(CW), .AW(AW)) dut6 (
        .clk(clk), .rst(rst), .cfg_valid(v6), .cfg_ready(r6),
        .cfg_addr(a6), .cfg_data(d6), .cfg_last(l6),
        .sample_valid(sv6), .hold(h6), .coeff_we(we6),
        .coeff_addr(ca6), .coeff_data(cd6), .commit_done(dn6),
        .err_clr(ec6), .cfg_err(ce6), .drop_err(de6)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what the shadow bank should hold and which flags should be set.
    logic signed [CW-1:0] m_shadow [NT];
    logic [NT-1:0]        m_mask;
    logic                 m_cfg_err, m_drop_err;

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_shadow[i] = '0;
        m_mask     = '0;
        m_cfg_err  = 1'b0;
        m_drop_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_last = 1'b0; sample_valid = 1'b0; err_clr = 1'b0;
        v6 = 1'b0; l6 = 1'b0; sv6 = 1'b0; ec6 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_cfg_err  = 1'b0;
        m_drop_err = 1'b0;
        #1;
        chk("err_clr_cfg", cfg_err, 0);
        chk("err_clr_drop", drop_err, 0);
    endtask

    // Present one beat, wait (bounded) until accepted, then update the model.
    task automatic send_beat(input logic [AW-1:0] a, input logic signed [CW-1:0] d,
                             input logic last, input logic sv_too);
        int n;
        n = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; cfg_last = last; sample_valid = sv_too;
        #1;
        while (!cfg_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cfg_ready) chk("beat_ready_timeout", {31'd0, cfg_ready}, 1);
        @(posedge clk);
        m_shadow[a] = d;
        m_mask[a]   = 1'b1;
        if (last && m_mask != '1) m_cfg_err = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_last = 1'b0; sample_valid = 1'b0;
    endtask

    task automatic send_full_set(input int seed);
        for (int i = 0; i < NT; i++)
            send_beat(AW'(i), CW'(seed + 37 * i), i == NT - 1, 1'b0);
    endtask

    // Strobe the boundary, then check every write cycle and the done pulse.
    // drop_at: COMMIT cycle carrying a stray sample; abort_at: cycle where rst is hit.
    task automatic do_commit(input int drop_at, input int abort_at);
        @(negedge clk);
        sample_valid = 1'b1;
        for (int k = 0; k < NT; k++) begin
            @(negedge clk);
            sample_valid = (k == drop_at);
            #1;
            chk($sformatf("we[%0d]", k), {31'd0, coeff_we}, 1);
            chk($sformatf("addr[%0d]", k), {29'd0, coeff_addr}, k);
            chk($sformatf("data[%0d]", k), 32'(coeff_data), 32'(m_shadow[k]));
            chk($sformatf("hold[%0d]", k), {31'd0, hold}, 1);
            chk($sformatf("nodone[%0d]", k), {31'd0, commit_done}, 0);
            if (k == abort_at) begin
                sample_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("rst_we", {31'd0, coeff_we}, 0);
                chk("rst_hold", {31'd0, hold}, 0);
                chk("rst_ready", {31'd0, cfg_ready}, 0);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                return;
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
        if (drop_at >= 0) m_drop_err = 1'b1;
        #1;
        chk("done", {31'd0, commit_done}, 1);
        chk("done_we", {31'd0, coeff_we}, 0);
        chk("done_hold", {31'd0, hold}, 0);
        chk("done_ready", {31'd0, cfg_ready}, 1);
        chk("drop_err", {31'd0, drop_err}, {31'd0, m_drop_err});
        m_mask = '0;
    endtask

    typedef struct {
        logic                 v;
        logic [AW-1:0]        a;
        logic signed [CW-1:0] d;
        logic                 last;
        logic                 sv;
        logic                 e_ready;
        logic                 e_we;
        logic [AW-1:0]        e_addr;
        logic signed [CW-1:0] e_data;
        logic                 e_hold;
        logic                 e_done;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [AW-1:0] a,
                                input logic signed [CW-1:0] d, input logic last,
                                input logic sv, input logic rdy, input logic we,
                                input logic [AW-1:0] ea, input logic signed [CW-1:0] ed,
                                input logic h, input logic dn);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.last = last; r.sv = sv;
        r.e_ready = rdy; r.e_we = we; r.e_addr = ea; r.e_data = ed;
        r.e_hold = h; r.e_done = dn;
        return r;
    endfunction

    vec_t tbl [19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic no_done, no_we;
        int   nb, drop;

        model_reset();
        // Test 1 table: 8 full beats, boundary strobe, 8 writes, done.
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1'b1, AW'(i), CW'(i + 1), i == 7, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tbl[8] = mk(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++)
            tbl[9 + j] = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(j), CW'(j + 1),
                            1'b1, 1'b0);
        tbl[17] = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        tbl[18] = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

        // Reset values
        rst = 1'b1;
        #1;
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 0);
        chk("rst_hold0", {31'd0, hold}, 0);
        chk("rst_we0", {31'd0, coeff_we}, 0);
        chk("rst_done0", {31'd0, commit_done}, 0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 0);
        chk("rst_drop_err", {31'd0, drop_err}, 0);
        chk("rst_addr", {29'd0, coeff_addr}, 0);
        chk("rst_data", 32'(coeff_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 19; r++) begin
            @(negedge clk);
            cfg_valid = tbl[r].v; cfg_addr = tbl[r].a; cfg_data = tbl[r].d;
            cfg_last = tbl[r].last; sample_valid = tbl[r].sv;
            #1;
            chk($sformatf("t1_ready[%0d]", r), {31'd0, cfg_ready}, {31'd0, tbl[r].e_ready});
            chk($sformatf("t1_we[%0d]", r), {31'd0, coeff_we}, {31'd0, tbl[r].e_we});
            chk($sformatf("t1_hold[%0d]", r), {31'd0, hold}, {31'd0, tbl[r].e_hold});
            chk($sformatf("t1_done[%0d]", r), {31'd0, commit_done}, {31'd0, tbl[r].e_done});
            if (tbl[r].e_we) begin
                chk($sformatf("t1_addr[%0d]", r), {29'd0, coeff_addr}, {29'd0, tbl[r].e_addr});
                chk($sformatf("t1_data[%0d]", r), 32'(coeff_data), 32'(tbl[r].e_data));
            end
        end
        cfg_valid = 1'b0; cfg_last = 1'b0; sample_valid = 1'b0;
        chk("t1_cfg_err", {31'd0, cfg_err}, 0);
        for (int i = 0; i < NT; i++) m_shadow[i] = CW'(i + 1);

        // Test 2: incomplete set, taps 6,7 keep their reset value
        do_reset();
        for (int t = 0; t < 6; t++) send_beat(AW'(t), -16'sd3, t == 5, 1'b0);
        #1;
        chk("t2_cfg_err", {31'd0, cfg_err}, 1);
        do_commit(-1, -1);
        clear_errs();

        // Test 3: NTAPS=6 instance, out-of-range beat, err_clr priority, no aliasing
        @(negedge clk);
        v6 = 1'b1; a6 = 3'd7; d6 = 16'sd99; l6 = 1'b0;
        #1;
        chk("t3_ready6", {31'd0, r6}, 1);
        @(negedge clk);
        a6 = 3'd6; ec6 = 1'b1;
        #1;
        chk("t3_err_set", {31'd0, ce6}, 1);
        @(negedge clk);
        v6 = 1'b0; ec6 = 1'b0;
        #1;
        chk("t3_err_wins", {31'd0, ce6}, 1);
        chk("t3_still_load", {31'd0, r6}, 1);
        @(negedge clk);
        ec6 = 1'b1;
        @(negedge clk);
        ec6 = 1'b0;
        #1;
        chk("t3_err_clr", {31'd0, ce6}, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v6 = 1'b1; a6 = AW'(i); d6 = CW'(10 + i); l6 = (i == 5);
        end
        @(negedge clk);
        v6 = 1'b0; l6 = 1'b0;
        #1;
        chk("t3_full_err", {31'd0, ce6}, 0);
        chk("t3_armed", {31'd0, r6}, 0);
        @(negedge clk);
        sv6 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sv6 = 1'b0;
            #1;
            chk($sformatf("t3_we[%0d]", k), {31'd0, we6}, 1);
            chk($sformatf("t3_data[%0d]", k), 32'(cd6), 32'(10 + k));
        end
        @(negedge clk);
        #1;
        chk("t3_done", {31'd0, dn6}, 1);

        // Test 4: stray sample in the 3rd COMMIT cycle
        send_full_set(100);
        do_commit(2, -1);
        chk("t4_drop_err", {31'd0, drop_err}, 1);
        clear_errs();

        // Test 5: reset at idx=4, then the shadow must read back zero
        send_full_set(-500);
        do_commit(-1, 4);
        #1;
        chk("t5_ready", {31'd0, cfg_ready}, 1);
        no_done = 1'b1;
        no_we   = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (commit_done) no_done = 1'b0;
            if (coeff_we) no_we = 1'b0;
        end
        chk("t5_no_done", {31'd0, no_done}, 1);
        chk("t5_no_we", {31'd0, no_we}, 1);
        send_beat(3'd0, 16'sd5, 1'b1, 1'b0);
        #1;
        chk("t5_cfg_err", {31'd0, cfg_err}, 1);
        do_commit(-1, -1);
        clear_errs();

        // Test 6: beat held through ARMED/COMMIT, accepted right after commit_done
        send_full_set(7);
        cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 16'sd77; cfg_last = 1'b1;
        #1;
        chk("t6_ready_armed", {31'd0, cfg_ready}, 0);
        do_commit(-1, -1);
        @(posedge clk);
        m_shadow[2] = 16'sd77;
        m_mask[2]   = 1'b1;
        m_cfg_err   = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_last = 1'b0;
        #1;
        chk("t6_armed_again", {31'd0, cfg_ready}, 0);
        chk("t6_cfg_err", {31'd0, cfg_err}, 1);
        do_commit(-1, -1);
        clear_errs();

        // Randomized sets against the model
        for (int it = 0; it < 25; it++) begin
            nb = int'($urandom_range(1, 10));
            for (int b = 0; b < nb; b++)
                send_beat(AW'($urandom_range(0, NT - 1)), CW'($urandom), b == nb - 1,
                          (b == nb - 1) && ($urandom_range(0, 1) == 1));
            #1;
            chk($sformatf("rnd_cfg_err[%0d]", it), {31'd0, cfg_err}, {31'd0, m_cfg_err});
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NT - 1)) : -1;
            do_commit(drop, -1);
            if ($urandom_range(0, 1) == 1) clear_errs();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
